// File: rtl/beeb816_pkg.sv
// Shared types and defaults for the beeb816 CPLD host-side logic.
//   hcs_state_t     : host cycle sequencer states
//   SYNC_STAGES_DEF : default bbc_phi0 synchronizer depth
//   SLOW_EXTRA_DEF  : default extra phi0 periods for FE4x/FC/FD pages
package beeb816_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_FALL = 3'd1,
      ST_ADDR      = 3'd2,
      ST_DATA      = 3'd3,
      ST_STRETCH   = 3'd4,
      ST_ACK       = 3'd5
   } hcs_state_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int SLOW_EXTRA_DEF  = 1;

endpackage

// File: rtl/phi_edge_sync.sv
// Synchronizes the host phi0 clock into the fast clock domain and produces
// one-clk rise/fall pulses from the last two synchronized samples.
//   clk       in  : fast CPU-side clock
//   resetb    in  : async active-low reset, clears all flops to 0
//   phi_async in  : host phi0, asynchronous to clk
//   rise      out : one-clk pulse after a synchronized 0->1 of phi0
//   fall      out : one-clk pulse after a synchronized 1->0 of phi0
module phi_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetb,
   input  logic phi_async,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   // sync_q[0] is the metastability-exposed stage; edges are only judged
   // between the final stage and its one-clk-delayed copy.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], phi_async};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~last_q;
   assign fall = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/host_cycle_seq.sv
// Host bus cycle sequencer: stalls the CPU on host-bus accesses, aligns each
// access to host phi0 and strobes the host address latch.
//   clk         in  : fast CPU-side clock (>= 8x phi0)
//   resetb      in  : async active-low reset
//   bbc_phi0    in  : host phi0, asynchronous
//   host_req    in  : CPU cycle targets the host bus, held until cpu_rdy
//   host_rnw    in  : CPU read=1 / write=0, sampled in IDLE
//   dec_fe4x    in  : slow-page flag, sampled in IDLE
//   lat_en      out : host address latch transparent while 1
//   cpu_rdy     out : 0 stalls the CPU
//   bbc_rnw     out : host bus read/write
//   bbc_data_oe out : drive CPU write data onto the host data bus
//   rdata_cap   out : one-clk host read data capture pulse
//   busy        out : host cycle in progress
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no host cycle; accept host_req, capture rnw and stretch count
// WAIT_FALL | request accepted, waiting for phi0 fall to start cleanly
// ADDR      | phi0 low phase; address latch open
// DATA      | phi0 high phase; write data driven, read data settling
// STRETCH   | extra phi0 low phase for slow pages; data bus released
// ACK       | one clk CPU release, then back to IDLE
module host_cycle_seq
   import beeb816_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int SLOW_EXTRA  = SLOW_EXTRA_DEF
) (
   input  logic clk,
   input  logic resetb,
   input  logic bbc_phi0,
   input  logic host_req,
   input  logic host_rnw,
   input  logic dec_fe4x,
   output logic lat_en,
   output logic cpu_rdy,
   output logic bbc_rnw,
   output logic bbc_data_oe,
   output logic rdata_cap,
   output logic busy
);

   localparam logic [1:0] SLOW_CNT = 2'(SLOW_EXTRA);

   hcs_state_t state;
   logic [1:0] cnt;
   logic       phi_rise;
   logic       phi_fall;

   phi_edge_sync #(
      .STAGES (SYNC_STAGES)
   ) u_phi_edge_sync (
      .clk       (clk),
      .resetb    (resetb),
      .phi_async (bbc_phi0),
      .rise      (phi_rise),
      .fall      (phi_fall)
   );

   // Registered outputs are updated on the same edge as the state they
   // decode, so they always match the current state.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state       <= ST_IDLE;
         cnt         <= 2'd0;
         lat_en      <= 1'b0;
         bbc_rnw     <= 1'b1;
         bbc_data_oe <= 1'b0;
         rdata_cap   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         rdata_cap <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (host_req) begin
                  state   <= ST_WAIT_FALL;
                  bbc_rnw <= host_rnw;
                  cnt     <= dec_fe4x ? SLOW_CNT : 2'd0;
                  busy    <= 1'b1;
               end
            end
            ST_WAIT_FALL: begin
               if (phi_fall) begin
                  state  <= ST_ADDR;
                  lat_en <= 1'b1;
               end
            end
            ST_ADDR: begin
               if (phi_rise) begin
                  state       <= ST_DATA;
                  lat_en      <= 1'b0;
                  bbc_data_oe <= ~bbc_rnw;
               end
            end
            ST_DATA: begin
               if (phi_fall) begin
                  bbc_data_oe <= 1'b0;
                  if (cnt != 2'd0) begin
                     cnt   <= cnt - 2'd1;
                     state <= ST_STRETCH;
                  end else begin
                     rdata_cap <= bbc_rnw;
                     state     <= ST_ACK;
                  end
               end
            end
            ST_STRETCH: begin
               if (phi_rise) begin
                  state       <= ST_DATA;
                  bbc_data_oe <= ~bbc_rnw;
               end
            end
            ST_ACK: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               bbc_rnw <= 1'b1;
            end
            default: begin
               state       <= ST_IDLE;
               cnt         <= 2'd0;
               lat_en      <= 1'b0;
               bbc_rnw     <= 1'b1;
               bbc_data_oe <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_rdy = ~host_req | (state == ST_ACK);

endmodule

// File: tb/tb_host_cycle_seq.sv
// Bench for host_cycle_seq: clk period 10, phi0 period 160 (16 clk) with a
// random phase offset. Each request pushes its expected host cycle onto a
// scoreboard queue; a monitor pops it when busy rises and compares the
// observed cycle when busy falls.
module tb_host_cycle_seq;

   localparam int SLOW_EXTRA = 1;

   logic clk = 1'b0;
   logic resetb = 1'b0;
   logic bbc_phi0 = 1'b0;
   logic host_req = 1'b0;
   logic host_rnw = 1'b1;
   logic dec_fe4x = 1'b0;
   logic lat_en, cpu_rdy, bbc_rnw, bbc_data_oe, rdata_cap, busy;

   host_cycle_seq #(
      .SYNC_STAGES (2),
      .SLOW_EXTRA  (SLOW_EXTRA)
   ) dut (
      .clk         (clk),
      .resetb      (resetb),
      .bbc_phi0    (bbc_phi0),
      .host_req    (host_req),
      .host_rnw    (host_rnw),
      .dec_fe4x    (dec_fe4x),
      .lat_en      (lat_en),
      .cpu_rdy     (cpu_rdy),
      .bbc_rnw     (bbc_rnw),
      .bbc_data_oe (bbc_data_oe),
      .rdata_cap   (rdata_cap),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      int off;
      off = $urandom_range(0, 31) * 5 + 2;
      #(off);
      forever #80 bbc_phi0 = ~bbc_phi0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, got timeout, want completion");
      $fatal(1);
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int want, input int tol = 0);
      n_chk++;
      if (got < want - tol || got > want + tol) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d) at %0t", tag, got, want, tol, $time);
      end
   endtask

   typedef struct {
      bit rnw;
      int extra;
      bit b2b;
   } txn_t;

   txn_t sb_q[$];
   txn_t cur;
   int   n_push = 0;
   int   n_done = 0;

   // Monitor
   int   cyc = 0;
   int   end_cyc = 0;
   bit   in_cyc = 0;
   int   lat_clks, oe_clks, oe_ph, caps, rnw_bad;
   int   stray = 0;
   logic prev_lat = 1'b0;
   logic prev_oe = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!resetb) begin
         in_cyc   = 0;
         prev_lat = 1'b0;
         prev_oe  = 1'b0;
      end else begin
         if (busy && !in_cyc) begin
            int pending;
            pending = (sb_q.size() > 0) ? 1 : 0;
            chk("sb_pending", pending, 1);
            if (pending != 0) cur = sb_q.pop_front();
            else cur = '{1'b1, 0, 1'b0};
            in_cyc   = 1;
            lat_clks = 0;
            oe_clks  = 0;
            oe_ph    = 0;
            caps     = 0;
            rnw_bad  = 0;
            if (cur.b2b) chk("b2b_gap", cyc - end_cyc, 1);
         end
         if (in_cyc) begin
            if (busy) begin
               if (lat_en) lat_clks++;
               if (lat_en && !prev_lat && cur.b2b)
                  chk("b2b_lat_gap", cyc - (end_cyc - 1), 16, 1);
               if (bbc_data_oe) oe_clks++;
               if (bbc_data_oe && !prev_oe) oe_ph++;
               if (rdata_cap) caps++;
               if (bbc_rnw !== cur.rnw) rnw_bad++;
            end else begin
               int ph;
               ph = cur.rnw ? 0 : 1 + cur.extra;
               chk("lat_len", lat_clks, 8, 1);
               chk("rdata_cap_cnt", caps, cur.rnw ? 1 : 0);
               chk("oe_phases", oe_ph, ph);
               chk("oe_len", oe_clks, 8 * ph, ph);
               chk("rnw_hold", rnw_bad, 0);
               in_cyc  = 0;
               end_cyc = cyc;
               n_done++;
            end
         end else if (lat_en || bbc_data_oe || rdata_cap) begin
            stray++;
         end
         prev_lat = lat_en;
         prev_oe  = bbc_data_oe;
      end
   end

   task automatic push_txn(input bit rnw, input bit fe4x, input bit b2b);
      txn_t t;
      t.rnw   = rnw;
      t.extra = fe4x ? SLOW_EXTRA : 0;
      t.b2b   = b2b;
      sb_q.push_back(t);
      n_push++;
   endtask

   task automatic do_req(input bit rnw, input bit fe4x, input bit align, input bit hold,
                         input bit b2b, input bit toggle, output int stall);
      bit got;
      if (align) begin
         @(posedge bbc_phi0);
         @(negedge clk);
      end
      push_txn(rnw, fe4x, b2b);
      host_rnw = rnw;
      dec_fe4x = fe4x;
      host_req = 1'b1;
      stall = 0;
      got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cpu_rdy) begin
            got = 1;
            break;
         end
         stall++;
         if (toggle && stall == 3) begin
            host_rnw = ~rnw;
            dec_fe4x = ~fe4x;
         end
         if (toggle && stall == 5) chk("rnw_kept", bbc_rnw, rnw);
      end
      chk("ack_seen", got, 1);
      chk("busy_at_ack", busy, 1);
      if (!hold) host_req = 1'b0;
      @(negedge clk);
      chk("busy_after_ack", busy, 0);
      chk("rdy_after_ack", cpu_rdy, hold ? 0 : 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_lat_en"}, lat_en, 0);
      chk({tag, "_bbc_rnw"}, bbc_rnw, 1);
      chk({tag, "_data_oe"}, bbc_data_oe, 0);
      chk({tag, "_rdata_cap"}, rdata_cap, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cpu_rdy"}, cpu_rdy, 1);
   endtask

   initial begin
      int  st_rd, st_nw, st_sw, st;
      int  n;
      bit  seen, prev_hold, hold;
      repeat (3) @(negedge clk);
      chk_reset_outs("rst0");
      resetb = 1'b1;
      repeat (20) @(negedge clk);

      // single normal read, issued just after phi0 rise
      do_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, st_rd);
      chk("rd_stall", st_rd, 27, 3);

      // normal write vs slow write at the same phi0 phase
      do_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, st_nw);
      do_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, st_sw);
      chk("slow_delta", st_sw - st_nw, 16, 1);

      // slow read, arbitrary phase
      repeat (5) @(negedge clk);
      do_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, st);

      // back-to-back: host_req held across ACK
      do_req(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, st);
      do_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, st);
      do_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, st);

      // host_req dropped during DATA
      @(posedge bbc_phi0);
      @(negedge clk);
      push_txn(1'b1, 1'b0, 1'b0);
      host_rnw = 1'b1;
      dec_fe4x = 1'b0;
      host_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (seen && !lat_en) break;
         if (lat_en) seen = 1;
      end
      host_req = 1'b0;
      chk("drop_in_data", (seen && !lat_en && busy) ? 1 : 0, 1);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (!busy) break;
      end
      chk("drop_tail", n, 9, 1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) n++;
      end
      chk("drop_no_restart", n, 0);

      // host_rnw / dec_fe4x changed after capture
      do_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, st);

      // reset while in ADDR
      push_txn(1'b1, 1'b0, 1'b0);
      host_rnw = 1'b1;
      dec_fe4x = 1'b0;
      host_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (lat_en) begin
            seen = 1;
            break;
         end
      end
      chk("addr_reached", seen, 1);
      #2;
      resetb   = 1'b0;
      host_req = 1'b0;
      #1;
      chk_reset_outs("rst_addr");
      host_req = 1'b1;
      #1;
      chk("rst_rdy_req", cpu_rdy, 0);
      host_req = 1'b0;
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      repeat (10) @(negedge clk);

      // recovery and a short random mix
      do_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st);
      prev_hold = 0;
      for (int k = 0; k < 6; k++) begin
         hold = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, hold,
                prev_hold, 1'b0, st);
         prev_hold = hold;
      end

      repeat (40) @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);
      chk("txn_done", n_done, n_push - 1);
      chk("stray_out", stray, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
